// File: rtl/mode_sequencer.sv
// Auto/manual control-word sequencer for the image-processor control word.
// Raw switches and buttons are synchronised and debounced. In auto mode a
// step counter advances on a programmable dwell (with pause and single-step)
// and the control word is assembled from bit-fields of that step count. The
// applied word can be held back until a vsync rising edge so that the mode
// never changes in the middle of a frame.
// The three fields are assumed not to overlap and to fit inside DATA_W.
module mode_sequencer #(
  parameter int DATA_W      = 9,
  parameter int DWELL       = 200_000_000,
  parameter int CNT_W       = 32,
  parameter int DEB_LEN     = 1_000_000,
  parameter int STEP_W      = 8,
  parameter int DISP_LSB    = 0,
  parameter int DISP_W      = 2,
  parameter int DISP_SHIFT  = 0,
  parameter int MODE_LSB    = 3,
  parameter int MODE_W      = 4,
  parameter int MODE_SHIFT  = 2,
  parameter int COLOR_LSB   = 7,
  parameter int COLOR_W     = 2,
  parameter int COLOR_SHIFT = 1,
  parameter int SYNC_VSYNC  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_sw,
  input  logic              i_auto,
  input  logic              i_pause,
  input  logic              i_step,
  input  logic              i_vsync,
  output logic [DATA_W-1:0] o_word,
  output logic              o_update,
  output logic [STEP_W-1:0] o_step,
  output logic              o_auto
);

  localparam int               DEB_W      = $clog2(DEB_LEN) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_LEN - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  // Bit positions of the scalar controls inside the packed control vectors.
  localparam int C_AUTO  = 0;
  localparam int C_PAUSE = 1;
  localparam int C_STEP  = 2;

  // Extracts step[shift +: width] (bits above STEP_W read as 0) and places
  // it at bit lsb of a control word.
  function automatic logic [DATA_W-1:0] f_field(input logic [STEP_W-1:0] step,
                                                input int lsb, input int width,
                                                input int shift);
    logic [STEP_W+DATA_W-1:0] ext;
    logic [STEP_W+DATA_W-1:0] mask;
    ext  = {{DATA_W{1'b0}}, step} >> shift;
    mask = '0;
    for (int b = 0; b < STEP_W + DATA_W; b++) begin
      if (b < width) mask[b] = 1'b1;
    end
    return DATA_W'(ext & mask) << lsb;
  endfunction

  logic [2:0]            w_ctl_raw;
  logic [2:0]            r_ctl_s1;
  logic [2:0]            r_ctl_s2;
  logic [2:0]            r_ctl_deb;
  logic [2:0][DEB_W-1:0] r_ctl_cnt;

  logic [DATA_W-1:0]     r_sw_s1;
  logic [DATA_W-1:0]     r_sw_s2;
  logic [DATA_W-1:0]     r_sw_s3;
  logic [DATA_W-1:0]     r_sw_deb;
  logic [DEB_W-1:0]      r_sw_cnt;

  logic                  r_step_prev;
  logic                  w_step_req;
  logic [CNT_W-1:0]      r_dwell;
  logic [STEP_W-1:0]     r_step;

  logic [DATA_W-1:0]     w_auto_word;
  logic [DATA_W-1:0]     r_cand;

  logic                  r_vs_s1;
  logic                  r_vs_s2;
  logic                  r_vs_prev;
  logic                  w_vs_rise;
  logic                  r_vs_apply;
  logic                  w_load;

  logic [DATA_W-1:0]     r_word;
  logic                  r_update;

  assign w_ctl_raw = {i_step, i_pause, i_auto};

  // Synchronise and debounce auto, pause and step, each with its own counter.
  // NOTE: every clocked assignment is non-blocking so all flops sample the
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl_s1  <= '0;
      r_ctl_s2  <= '0;
      r_ctl_deb <= '0;
      r_ctl_cnt <= '0;
    end else begin
      r_ctl_s1 <= w_ctl_raw;
      r_ctl_s2 <= r_ctl_s1;
      for (int i = 0; i < 3; i++) begin
        if (r_ctl_s2[i] == r_ctl_deb[i]) begin
          r_ctl_cnt[i] <= '0;
        end else if (r_ctl_cnt[i] == DEB_LAST) begin
          r_ctl_deb[i] <= r_ctl_s2[i];
          r_ctl_cnt[i] <= '0;
        end else begin
          r_ctl_cnt[i] <= r_ctl_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Synchronise the switch bank and debounce it as one vector; any movement
  // of the synced vector restarts the stability count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_sw_s3  <= '0;
      r_sw_deb <= '0;
      r_sw_cnt <= '0;
    end else begin
      r_sw_s1 <= i_sw;
      r_sw_s2 <= r_sw_s1;
      r_sw_s3 <= r_sw_s2;
      if (r_sw_s2 == r_sw_deb) begin
        r_sw_cnt <= '0;
      end else if (r_sw_s2 != r_sw_s3) begin
        r_sw_cnt <= '0;
      end else if (r_sw_cnt == DEB_LAST) begin
        r_sw_deb <= r_sw_s2;
        r_sw_cnt <= '0;
      end else begin
        r_sw_cnt <= r_sw_cnt + DEB_W'(1);
      end
    end
  end

  assign w_step_req = r_ctl_deb[C_STEP] & ~r_step_prev;

  // Dwell timer and step counter: free-run in auto, hold on pause, advance
  // once per step request (a request on the expiry cycle counts only once).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_prev <= 1'b0;
      r_dwell     <= '0;
      r_step      <= '0;
    end else begin
      r_step_prev <= r_ctl_deb[C_STEP];
      if (!r_ctl_deb[C_AUTO]) begin
        r_dwell <= '0;
      end else if (w_step_req) begin
        r_step  <= r_step + STEP_W'(1);
        r_dwell <= '0;
      end else if (!r_ctl_deb[C_PAUSE]) begin
        if (r_dwell == DWELL_LAST) begin
          r_dwell <= '0;
          r_step  <= r_step + STEP_W'(1);
        end else begin
          r_dwell <= r_dwell + CNT_W'(1);
        end
      end
    end
  end

  // Assemble the auto control word from the step-count fields.
  // NOTE: the variable gets a full default before any partial assignment, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_auto_word = '0;
    w_auto_word = w_auto_word
                | f_field(r_step, DISP_LSB,  DISP_W,  DISP_SHIFT)
                | f_field(r_step, MODE_LSB,  MODE_W,  MODE_SHIFT)
                | f_field(r_step, COLOR_LSB, COLOR_W, COLOR_SHIFT);
  end

  assign w_vs_rise = r_vs_s2 & ~r_vs_prev;
  assign w_load    = (SYNC_VSYNC == 0) ? 1'b1 : r_vs_apply;

  // Vsync synchroniser and registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_s1    <= 1'b0;
      r_vs_s2    <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_vs_apply <= 1'b0;
    end else begin
      r_vs_s1    <= i_vsync;
      r_vs_s2    <= r_vs_s1;
      r_vs_prev  <= r_vs_s2;
      r_vs_apply <= w_vs_rise;
    end
  end

  // Candidate selection and gated application of the control word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand   <= '0;
      r_word   <= '0;
      r_update <= 1'b0;
    end else begin
      r_cand   <= r_ctl_deb[C_AUTO] ? w_auto_word : r_sw_deb;
      r_update <= 1'b0;
      if (w_load) begin
        r_word   <= r_cand;
        r_update <= (r_cand != r_word);
      end
    end
  end

  assign o_word   = r_word;
  assign o_update = r_update;
  assign o_step   = r_step;
  assign o_auto   = r_ctl_deb[C_AUTO];

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with DWELL=8 and DEB_LEN=4. Two instances
// share the stimulus: u_imm applies words immediately, u_vs waits for vsync.
module tb_mode_sequencer;

  localparam int DATA_W  = 9;
  localparam int STEP_W  = 8;
  localparam int DWELL   = 8;
  localparam int DEB_LEN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] i_sw;
  logic              i_auto;
  logic              i_pause;
  logic              i_step;
  logic              i_vsync;

  logic [DATA_W-1:0] word0, word1;
  logic              upd0, upd1;
  logic [STEP_W-1:0] step0, step1;
  logic              auto0, auto1;

  int checks = 0;
  int errors = 0;
  int n_upd0 = 0;
  int n_upd1 = 0;

  typedef struct {
    logic [DATA_W-1:0] sw;
    int                hold;
    logic [DATA_W-1:0] exp_word;
    int                exp_upd;
  } vec_t;

  vec_t vecs [5];

  mode_sequencer #(.DATA_W(DATA_W), .DWELL(DWELL), .CNT_W(32), .DEB_LEN(DEB_LEN),
                   .STEP_W(STEP_W), .SYNC_VSYNC(0)) u_imm (
    .clk(clk), .reset(reset), .i_sw(i_sw), .i_auto(i_auto), .i_pause(i_pause),
    .i_step(i_step), .i_vsync(i_vsync), .o_word(word0), .o_update(upd0),
    .o_step(step0), .o_auto(auto0));

  mode_sequencer #(.DATA_W(DATA_W), .DWELL(DWELL), .CNT_W(32), .DEB_LEN(DEB_LEN),
                   .STEP_W(STEP_W), .SYNC_VSYNC(1)) u_vs (
    .clk(clk), .reset(reset), .i_sw(i_sw), .i_auto(i_auto), .i_pause(i_pause),
    .i_step(i_step), .i_vsync(i_vsync), .o_word(word1), .o_update(upd1),
    .o_step(step1), .o_auto(auto1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n clock edges; sample 1 ns after each edge and count update pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (upd0 === 1'b1) n_upd0++;
      if (upd1 === 1'b1) n_upd1++;
    end
  endtask

  // Default field map: disp=step[1:0]@0, mode=step[5:2]@3, color=step[2:1]@7.
  function automatic logic [DATA_W-1:0] model_word(input logic [STEP_W-1:0] s);
    logic [DATA_W-1:0] w;
    w      = '0;
    w[1:0] = s[1:0];
    w[6:3] = s[5:2];
    w[8:7] = s[2:1];
    return w;
  endfunction

  // Wait (bounded) for o_step of u_imm to change.
  task automatic wait_step_change(input string name);
    logic [STEP_W-1:0] prev;
    bit                seen;
    prev = step0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (step0 != prev) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Watch 16 edges, returning the edge index of the first two step changes
  // and the step value right after the first one.
  task automatic watch_steps(output int first, output int second,
                             output logic [STEP_W-1:0] first_val);
    logic [STEP_W-1:0] last;
    last      = step0;
    first     = -1;
    second    = -1;
    first_val = '0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (step0 != last) begin
        if (first < 0) begin
          first     = k;
          first_val = step0;
        end else if (second < 0) begin
          second = k;
        end
        last = step0;
      end
    end
  endtask

  initial begin
    int                first, second, k_upd;
    logic [STEP_W-1:0] base, held, fval;
    bit                seen;

    vecs[0] = '{9'h155, 14, 9'h155, 1};
    vecs[1] = '{9'h0AA, 14, 9'h0AA, 1};
    vecs[2] = '{9'h0AA, 14, 9'h0AA, 0};
    vecs[3] = '{9'h1FF, 14, 9'h1FF, 1};
    vecs[4] = '{9'h155, 14, 9'h155, 1};

    reset   = 1'b1;
    i_sw    = '0;
    i_auto  = 1'b0;
    i_pause = 1'b0;
    i_step  = 1'b0;
    i_vsync = 1'b0;
    tick(3);
    check("reset_word",   32'(word0), 32'h0);
    check("reset_update", 32'(upd0),  32'h0);
    check("reset_step",   32'(step0), 32'h0);
    check("reset_auto",   32'(auto0), 32'h0);
    check("reset_word_vs", 32'(word1), 32'h0);
    reset = 1'b0;
    tick(2);

    // Manual mode: debounced switches reach o_word; equal value gives no pulse.
    foreach (vecs[v]) begin
      i_sw   = vecs[v].sw;
      n_upd0 = 0;
      tick(vecs[v].hold);
      check($sformatf("man_word[%0d]", v), 32'(word0), 32'(vecs[v].exp_word));
      check($sformatf("man_upd[%0d]", v),  n_upd0,     vecs[v].exp_upd);
      check($sformatf("man_step[%0d]", v), 32'(step0), 32'h0);
    end
    check("vs_hold_no_edge", 32'(word1), 32'h0);
    check("vs_no_update",    n_upd1,     0);

    // Two-cycle glitch is rejected.
    n_upd0 = 0;
    i_sw = 9'h000;
    tick(2);
    i_sw = 9'h155;
    tick(14);
    check("glitch2_word", 32'(word0), 32'h155);
    check("glitch2_upd",  n_upd0,     0);

    // Six-cycle glitch is accepted, one pulse, then the switch returns.
    i_sw = 9'h000;
    tick(6);
    i_sw = 9'h155;
    tick(4);
    check("glitch6_word", 32'(word0), 32'h000);
    check("glitch6_upd",  n_upd0,     1);
    tick(14);
    check("glitch6_back", 32'(word0), 32'h155);
    check("glitch6_upd2", n_upd0,     2);

    // Vsync gating: load lands 4 edges after vsync rises.
    check("vs_pre_edge", 32'(word1), 32'h0);
    n_upd1  = 0;
    k_upd   = -1;
    i_vsync = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (upd1 === 1'b1 && k_upd < 0) k_upd = k;
    end
    i_vsync = 1'b0;
    tick(4);
    check("vs_latency",  k_upd,      4);
    check("vs_one_upd",  n_upd1,     1);
    check("vs_word",     32'(word1), 32'h155);

    // Intermediate candidates between edges are dropped.
    n_upd1 = 0;
    i_sw = 9'h011;
    tick(14);
    i_sw = 9'h022;
    tick(14);
    check("vs_held",      32'(word1), 32'h155);
    check("vs_held_upd",  n_upd1,     0);
    check("imm_follows",  32'(word0), 32'h022);
    i_vsync = 1'b1;
    tick(8);
    i_vsync = 1'b0;
    tick(4);
    check("vs_last_cand", 32'(word1), 32'h022);
    check("vs_last_upd",  n_upd1,     1);

    // Vsync edge with unchanged candidate: load without pulse.
    n_upd1  = 0;
    i_vsync = 1'b1;
    tick(8);
    i_vsync = 1'b0;
    tick(4);
    check("vs_equal_noupd", n_upd1, 0);

    // Enter auto, run a while, then reset mid-dwell.
    i_auto = 1'b1;
    tick(30);
    reset = 1'b1;
    tick(1);
    check("midreset_word",   32'(word0), 32'h0);
    check("midreset_step",   32'(step0), 32'h0);
    check("midreset_update", 32'(upd0),  32'h0);
    check("midreset_auto",   32'(auto0), 32'h0);
    reset = 1'b0;

    // Auto re-debounces; dwell restarts from 0 once auto is accepted.
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (auto0 === 1'b1) seen = 1;
    end
    check("auto_debounced", 32'(seen), 32'd1);
    for (int k = 1; k <= 45; k++) begin
      tick(1);
      if (k == 7)  check("auto_step_k7",  32'(step0), 32'd0);
      if (k == 8)  check("auto_step_k8",  32'(step0), 32'd1);
      if (k == 32) check("auto_step_k32", 32'(step0), 32'd4);
      if (k == 45) begin
        check("auto_step_k45", 32'(step0), 32'd5);
        check("auto_word_s5",  32'(word0), 32'(model_word(8'd5)));
      end
    end

    // Pause freezes the step; a step press still advances it.
    i_pause = 1'b1;
    tick(10);
    held = step0;
    tick(50);
    check("pause_frozen",     32'(step0), 32'(held));
    check("pause_word",       32'(word0), 32'(model_word(held)));
    i_step = 1'b1;
    tick(10);
    i_step = 1'b0;
    tick(10);
    check("pause_step_press", 32'(step0), 32'(8'(held + 8'd1)));
    i_pause = 1'b0;
    tick(10);

    // Step press mid-dwell: +1 at edge 7, dwell cleared so next at edge 15.
    wait_step_change("sync_mid");
    base   = step0;
    i_step = 1'b1;
    watch_steps(first, second, fval);
    i_step = 1'b0;
    check("mid_first_edge",  first,      7);
    check("mid_first_val",   32'(fval),  32'(8'(base + 8'd1)));
    check("mid_second_edge", second,     15);
    tick(10);

    // Step press on the dwell-expiry edge: single increment.
    wait_step_change("sync_coinc");
    tick(1);
    base   = step0;
    i_step = 1'b1;
    watch_steps(first, second, fval);
    i_step = 1'b0;
    check("coinc_first_edge",  first,     7);
    check("coinc_first_val",   32'(fval), 32'(8'(base + 8'd1)));
    check("coinc_second_edge", second,    15);
    tick(10);

    // Wrap from 255 to 0 with a word update.
    seen = 0;
    for (int i = 0; i < 2200 && !seen; i++) begin
      tick(1);
      if (step0 == 8'd255) seen = 1;
    end
    check("reach_255", 32'(seen), 32'd1);
    check("word_255",  32'(word0 == model_word(8'd255) || word0 == model_word(8'd254)), 32'd1);
    wait_step_change("wrap_change");
    check("wrap_step", 32'(step0), 32'd0);
    tick(2);
    check("wrap_word",   32'(word0), 32'(model_word(8'd0)));
    check("wrap_update", 32'(upd0),  32'd1);

    // Back to manual: step holds, switches drive the word again.
    i_auto = 1'b0;
    tick(12);
    held = step0;
    tick(30);
    check("manual_step_hold", 32'(step0), 32'(held));
    check("manual_auto",      32'(auto0), 32'd0);
    check("manual_word",      32'(word0), 32'h022);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
